// File: rtl/mole_line_fetcher_pkg.sv
// Shared constants and FSM encoding for the mole sprite line fetcher.
package mole_pkg;
  localparam int SPRITE_W  = 64;
  localparam int SPRITE_H  = 32;
  localparam int GRID_COLS = 3;
  localparam int GRID_ROWS = 3;
  localparam int NUM_HOLES = GRID_COLS * GRID_ROWS;
  localparam logic [3:0] NO_HOLE = 4'd15;

  typedef enum logic [2:0] {IDLE, SETUP, F0, F1, F2} fetch_state_e;
endpackage

// File: rtl/mole_line_fetcher_if.sv
// Sprite ROM port: the fetcher drives the row address, the ROM answers combinationally.
interface mole_line_fetcher_if;
  import mole_pkg::*;

  logic [4:0]          rom_row;
  logic [SPRITE_W-1:0] rom_data;

  modport master (output rom_row, input rom_data);
  modport slave  (input rom_row, output rom_data);
endinterface

// File: rtl/mole_hole_locator.sv
// Combinational: finds the band hit by a scanline and the bottom-aligned sprite row
// each hole in that band needs, given its pop-up level.
module mole_hole_locator
  import mole_pkg::*;
#(
  parameter int HOLE_Y0 = 112,
  parameter int PITCH_Y = 128
) (
  input  logic [9:0]                  i_next_y,
  input  logic [NUM_HOLES-1:0]        i_mole_up,
  input  logic [6*NUM_HOLES-1:0]      i_pop_level,
  output logic                        o_hit,
  output logic [1:0]                  o_band,
  output logic [GRID_COLS-1:0][4:0]   o_row,
  output logic [GRID_COLS-1:0]        o_valid
);

  always_comb begin
    logic [9:0] w_top;
    logic [4:0] w_r;
    logic [3:0] w_h;
    logic [5:0] w_base;
    logic [5:0] w_lvl;
    logic [5:0] w_thr;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    o_hit   = 1'b0;
    o_band  = '0;
    o_row   = '0;
    o_valid = '0;
    w_r     = '0;
    w_top   = '0;
    for (int b = 0; b < GRID_ROWS; b++) begin
      w_top = 10'(HOLE_Y0 + b * PITCH_Y);
      // Offset is only taken once the lower bound holds, so it never wraps.
      if (i_next_y >= w_top && (i_next_y - w_top) < 10'(SPRITE_H)) begin
        o_hit  = 1'b1;
        o_band = 2'(b);
        w_r    = 5'(i_next_y - w_top);
      end
    end
    for (int c = 0; c < GRID_COLS; c++) begin
      w_h    = {2'b00, o_band} * 4'd3 + 4'(c);
      w_base = 6'(w_h) * 6'd6;
      w_lvl  = i_pop_level[w_base +: 6];
      if (w_lvl > 6'(SPRITE_H)) w_lvl = 6'(SPRITE_H);
      w_thr  = 6'(SPRITE_H) - w_lvl;
      o_valid[c] = o_hit & i_mole_up[w_h] & (w_lvl != 6'd0) & ({1'b0, w_r} >= w_thr);
      o_row[c]   = o_valid[c] ? 5'({1'b0, w_r} - w_thr) : 5'd0;
    end
  end

endmodule

// File: rtl/mole_line_fetcher.sv
// Fetches the three sprite rows of the upcoming scanline's band during hblank and
// serializes them into a registered per-pixel opacity/hole stream during active video.
module mole_line_fetcher
  import mole_pkg::*;
#(
  parameter int HOLE_X0 = 96,
  parameter int PITCH_X = 192,
  parameter int HOLE_Y0 = 112,
  parameter int PITCH_Y = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   line_start,
  input  logic [9:0]             next_y,
  input  logic [9:0]             x,
  input  logic                   video_on,
  input  logic [NUM_HOLES-1:0]   mole_up,
  input  logic [6*NUM_HOLES-1:0] pop_level,
  mole_line_fetcher_if.master    rom,
  output logic                   pixel_on,
  output logic [3:0]             pixel_hole,
  output logic                   busy,
  output logic                   fetch_done,
  output logic                   overrun
);

  if (PITCH_X < SPRITE_W) begin : g_pitch_check
    $error("PITCH_X smaller than SPRITE_W would make columns overlap");
  end

  fetch_state_e                r_state;
  logic [9:0]                  r_y;
  logic [NUM_HOLES-1:0]        r_up;
  logic [6*NUM_HOLES-1:0]      r_pop;
  logic [4:0]                  r_rom_row;
  logic [SPRITE_W-1:0]         r_buf [GRID_COLS];
  logic [GRID_COLS-1:0]        r_valid;
  logic [1:0]                  r_band;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_overrun;
  logic                        r_pixel_on;
  logic [3:0]                  r_pixel_hole;

  logic                        w_hit;
  logic [1:0]                  w_band;
  logic [GRID_COLS-1:0][4:0]   w_row;
  logic [GRID_COLS-1:0]        w_valid;

  mole_hole_locator #(.HOLE_Y0(HOLE_Y0), .PITCH_Y(PITCH_Y)) u_locator (
    .i_next_y    (r_y),
    .i_mole_up   (r_up),
    .i_pop_level (r_pop),
    .o_hit       (w_hit),
    .o_band      (w_band),
    .o_row       (w_row),
    .o_valid     (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_y       <= '0;
      r_up      <= '0;
      r_pop     <= '0;
      r_rom_row <= '0;
      // NOTE: the line buffers are three plain registers, not a RAM, so clearing them here is cheap.
      for (int c = 0; c < GRID_COLS; c++) r_buf[c] <= '0;
      r_valid   <= '0;
      r_band    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (line_start && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (line_start) begin
          r_y     <= next_y;
          r_up    <= mole_up;
          r_pop   <= pop_level;
          r_busy  <= 1'b1;
          r_state <= SETUP;
        end
        SETUP: begin
          r_rom_row <= w_row[0];
          r_state   <= F0;
        end
        F0: begin
          r_buf[0]   <= rom.rom_data;
          r_valid[0] <= w_valid[0];
          r_band     <= w_hit ? w_band : 2'd0;
          r_rom_row  <= w_row[1];
          r_state    <= F1;
        end
        F1: begin
          r_buf[1]   <= rom.rom_data;
          r_valid[1] <= w_valid[1];
          r_rom_row  <= w_row[2];
          r_state    <= F2;
        end
        F2: begin
          r_buf[2]   <= rom.rom_data;
          r_valid[2] <= w_valid[2];
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic       w_sel_on;
  logic [3:0] w_sel_hole;

  always_comb begin
    logic [9:0] w_colx;
    logic [5:0] w_off;
    w_sel_on   = 1'b0;
    w_sel_hole = NO_HOLE;
    w_colx     = '0;
    w_off      = '0;
    for (int c = 0; c < GRID_COLS; c++) begin
      w_colx = 10'(HOLE_X0 + c * PITCH_X);
      if (r_valid[c] && x >= w_colx && (x - w_colx) < 10'(SPRITE_W)) begin
        w_off = 6'(x - w_colx);
        if (r_buf[c][6'd63 - w_off]) begin
          w_sel_on   = 1'b1;
          w_sel_hole = {2'b00, r_band} * 4'd3 + 4'(c);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_on   <= 1'b0;
      r_pixel_hole <= NO_HOLE;
    end else begin
      r_pixel_on   <= video_on & w_sel_on;
      r_pixel_hole <= (video_on & w_sel_on) ? w_sel_hole : NO_HOLE;
    end
  end

  assign rom.rom_row = r_rom_row;
  assign pixel_on    = r_pixel_on;
  assign pixel_hole  = r_pixel_hole;
  assign busy        = r_busy;
  assign fetch_done  = r_done;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_mole_line_fetcher.sv
// Self-checking bench: directed scenarios plus randomized lines against a geometric reference model.
module tb_mole_line_fetcher;
  import mole_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  next_y = '0;
  logic [9:0]  x = '0;
  logic        video_on = 1'b0;
  logic [8:0]  mole_up = '0;
  logic [53:0] pop_level = '0;
  logic        pixel_on, busy, fetch_done, overrun;
  logic [3:0]  pixel_hole;

  mole_line_fetcher_if rom_if ();
  logic [63:0] rom_mem [32];
  assign rom_if.rom_data = rom_mem[rom_if.rom_row];

  mole_line_fetcher dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .next_y     (next_y),
    .x          (x),
    .video_on   (video_on),
    .mole_up    (mole_up),
    .pop_level  (pop_level),
    .rom        (rom_if),
    .pixel_on   (pixel_on),
    .pixel_hole (pixel_hole),
    .busy       (busy),
    .fetch_done (fetch_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: what each column should currently display.
  logic [63:0] m_line [3];
  bit          m_valid [3];
  int          m_band;
  int          m_row [3];

  // Per-fetch observations, index = posedges after line_start was raised.
  bit         obs_busy [9];
  logic [4:0] obs_row  [9];
  int         obs_done_at, obs_done_cnt;

  function automatic void model_fetch(input int y, input logic [8:0] up, input logic [53:0] pop);
    bit hit = 0;
    int bb = 0, rr = 0;
    for (int b = 0; b < 3; b++) begin
      int top = 112 + b * 128;
      if (y >= top && y < top + 32) begin hit = 1; bb = b; rr = y - top; end
    end
    m_band = bb;
    for (int c = 0; c < 3; c++) begin
      int h = bb * 3 + c;
      int lvl = int'(pop[6*h +: 6]);
      if (lvl > 32) lvl = 32;
      m_valid[c] = hit && up[h] && lvl > 0 && rr >= 32 - lvl;
      m_row[c]   = m_valid[c] ? rr - (32 - lvl) : 0;
      m_line[c]  = rom_mem[m_row[c]];
    end
  endfunction

  function automatic void model_pix(input int xx, input bit vid, output bit on, output logic [3:0] hole);
    on = 0; hole = 4'd15;
    if (vid) for (int c = 0; c < 3; c++) begin
      int lo = 96 + c * 192;
      if (xx >= lo && xx < lo + 64 && m_valid[c] && m_line[c][63 - (xx - lo)]) begin
        on = 1; hole = 4'(m_band * 3 + c);
      end
    end
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin m_valid[c] = 0; m_line[c] = '0; m_row[c] = 0; end
    m_band = 0;
  endtask

  task automatic run_fetch(input int y, input logic [8:0] up, input logic [53:0] pop);
    next_y = 10'(y); mole_up = up; pop_level = pop;
    @(negedge clk); line_start = 1'b1;
    obs_done_at = 0; obs_done_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      line_start = 1'b0;
      obs_busy[k] = busy;
      obs_row[k]  = rom_if.rom_row;
      if (fetch_done) begin obs_done_cnt++; if (obs_done_at == 0) obs_done_at = k; end
    end
    model_fetch(y, up, pop);
  endtask

  task automatic drive_x(input int xx, input bit vid);
    @(negedge clk); x = 10'(xx); video_on = vid;
    @(posedge clk); #1;
  endtask

  task automatic sweep_line(input bit rand_vid, output int n_bad, output int n_on,
                            output logic [3:0] last_hole, output string msg);
    n_bad = 0; n_on = 0; last_hole = 4'd15; msg = "";
    for (int xx = 0; xx < 640; xx++) begin
      bit vid, e_on;
      logic [3:0] e_hole;
      vid = rand_vid ? ($urandom_range(0, 3) != 0) : 1'b1;
      model_pix(xx, vid, e_on, e_hole);
      drive_x(xx, vid);
      if (pixel_on === 1'b1) begin n_on++; last_hole = pixel_hole; end
      if (pixel_on !== e_on || pixel_hole !== e_hole) begin
        if (n_bad == 0) msg = $sformatf("x=%0d on=%b want %b hole=%0d want %0d", xx, pixel_on, e_on, pixel_hole, e_hole);
        n_bad++;
      end
    end
    @(negedge clk); video_on = 1'b0;
  endtask

  task automatic test_reset();
    int nb, non; logic [3:0] lh; string msg;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (pixel_on !== 1'b0) $display("FAIL reset_pixel_on: got %b want 0", pixel_on); else n_pass++;
    n_total++; if (pixel_hole !== 4'd15) $display("FAIL reset_pixel_hole: got %0d want 15", pixel_hole); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (rom_if.rom_row !== 5'd0) $display("FAIL reset_rom_row: got %0d want 0", rom_if.rom_row); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
    n_total++; if (fetch_done !== 1'b0) $display("FAIL reset_fetch_done: got %b want 0", fetch_done); else n_pass++;
    @(negedge clk); reset = 1'b0;
    model_clear();
    sweep_line(1'b0, nb, non, lh, msg);
    n_total++; if (non !== 0) $display("FAIL reset_sweep: got %0d opaque pixels want 0", non); else n_pass++;
  endtask

  task automatic test_full_mole();
    int nb, non; logic [3:0] lh; string msg;
    run_fetch(112, 9'h001, 54'd32);
    n_total++; if (obs_row[2] !== 5'd0) $display("FAIL full_rom_row_f0: got %0d want 0", obs_row[2]); else n_pass++;
    n_total++; if (obs_done_at !== 5 || obs_done_cnt !== 1) $display("FAIL full_done_timing: got at %0d x%0d want at 5 x1", obs_done_at, obs_done_cnt); else n_pass++;
    n_total++; if (!(obs_busy[1] && obs_busy[4] && !obs_busy[5])) $display("FAIL full_busy: got %b%b want 10", obs_busy[4], obs_busy[5]); else n_pass++;
    drive_x(96, 1'b1);
    n_total++; if (pixel_on !== 1'b0) $display("FAIL full_x96: got %b want 0", pixel_on); else n_pass++;
    drive_x(113, 1'b1);
    n_total++; if (pixel_on !== 1'b1 || pixel_hole !== 4'd0) $display("FAIL full_x113: got on=%b hole=%0d want on=1 hole=0", pixel_on, pixel_hole); else n_pass++;
    drive_x(113, 1'b0);
    n_total++; if (pixel_on !== 1'b0 || pixel_hole !== 4'd15) $display("FAIL full_blanked: got on=%b hole=%0d want 0/15", pixel_on, pixel_hole); else n_pass++;
    sweep_line(1'b0, nb, non, lh, msg);
    n_total++; if (nb !== 0) $display("FAIL full_sweep: %0d bad, first %s", nb, msg); else n_pass++;
    n_total++; if (non !== $countones(rom_mem[0])) $display("FAIL full_opaque_count: got %0d want %0d", non, $countones(rom_mem[0])); else n_pass++;
  endtask

  task automatic test_mid_fetch_reset();
    int nb, non, dcnt; logic [3:0] lh; string msg;
    next_y = 10'd112; mole_up = 9'h007; pop_level = {9{6'd32}};
    @(negedge clk); line_start = 1'b1;
    @(posedge clk); #1; line_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0 || rom_if.rom_row !== 5'd0) $display("FAIL midreset_state: got busy=%b row=%0d want 0/0", busy, rom_if.rom_row); else n_pass++;
    @(negedge clk); reset = 1'b0;
    model_clear();
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (fetch_done) dcnt++; end
    n_total++; if (dcnt !== 0) $display("FAIL midreset_no_done: got %0d pulses want 0", dcnt); else n_pass++;
    sweep_line(1'b0, nb, non, lh, msg);
    n_total++; if (non !== 0) $display("FAIL midreset_buffers: got %0d opaque want 0", non); else n_pass++;
  endtask

  task automatic test_partial_rise();
    int nb, non; logic [3:0] lh; string msg;
    logic [53:0] pop = '0;
    pop[24 +: 6] = 6'd8;
    run_fetch(270, 9'h010, pop);
    n_total++; if (obs_row[3] !== 5'd6) $display("FAIL partial_rom_row_f1: got %0d want 6", obs_row[3]); else n_pass++;
    n_total++; if (obs_done_at !== 5) $display("FAIL partial_done_at: got %0d want 5", obs_done_at); else n_pass++;
    sweep_line(1'b0, nb, non, lh, msg);
    n_total++; if (nb !== 0) $display("FAIL partial_sweep: %0d bad, first %s", nb, msg); else n_pass++;
    n_total++; if (non !== $countones(rom_mem[6]) || lh !== 4'd4) $display("FAIL partial_hole4: got %0d opaque hole %0d want %0d hole 4", non, lh, $countones(rom_mem[6])); else n_pass++;
  endtask

  task automatic test_hidden_row();
    int nb, non; logic [3:0] lh; string msg;
    logic [53:0] pop = '0;
    pop[24 +: 6] = 6'd8;
    run_fetch(252, 9'h010, pop);
    n_total++; if (obs_row[3] !== 5'd0) $display("FAIL hidden_rom_row: got %0d want 0", obs_row[3]); else n_pass++;
    sweep_line(1'b0, nb, non, lh, msg);
    n_total++; if (non !== 0) $display("FAIL hidden_sweep: got %0d opaque want 0", non); else n_pass++;
  endtask

  task automatic test_no_band();
    int nb, non; logic [3:0] lh; string msg;
    run_fetch(200, 9'h1FF, {9{6'd32}});
    n_total++; if (obs_done_at !== 5 || obs_done_cnt !== 1) $display("FAIL noband_done: got at %0d x%0d want at 5 x1", obs_done_at, obs_done_cnt); else n_pass++;
    sweep_line(1'b0, nb, non, lh, msg);
    n_total++; if (non !== 0) $display("FAIL noband_sweep: got %0d opaque want 0", non); else n_pass++;
  endtask

  task automatic test_overrun();
    int nb, non, dcnt, dat; logic [3:0] lh; string msg;
    n_total++; if (overrun !== 1'b0) $display("FAIL overrun_initial: got %b want 0", overrun); else n_pass++;
    next_y = 10'd112; mole_up = 9'h001; pop_level = 54'd32;
    model_fetch(112, 9'h001, 54'd32);
    @(negedge clk); line_start = 1'b1;
    dcnt = 0; dat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      line_start = (k == 2);
      if (fetch_done) begin dcnt++; if (dat == 0) dat = k; end
    end
    n_total++; if (dcnt !== 1 || dat !== 5) $display("FAIL overrun_no_restart: got %0d pulses at %0d want 1 at 5", dcnt, dat); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun); else n_pass++;
    sweep_line(1'b0, nb, non, lh, msg);
    n_total++; if (nb !== 0) $display("FAIL overrun_sweep: %0d bad, first %s", nb, msg); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun); else n_pass++;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (overrun !== 1'b0) $display("FAIL overrun_cleared: got %b want 0", overrun); else n_pass++;
    @(negedge clk); reset = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    int nb, non, y; logic [3:0] lh; string msg;
    logic [53:0] pop;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 32; i++) rom_mem[i] = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) y = 112 + 128 * $urandom_range(0, 2) + $urandom_range(0, 31);
      else y = $urandom_range(0, 479);
      for (int h = 0; h < 9; h++) pop[6*h +: 6] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
      run_fetch(y, 9'($urandom), pop);
      n_total++;
      if (obs_done_at !== 5 || obs_row[2] !== 5'(m_row[0]) || obs_row[3] !== 5'(m_row[1]) || obs_row[4] !== 5'(m_row[2]))
        $display("FAIL rand_fetch[%0d]: y=%0d done_at %0d rows %0d,%0d,%0d want 5 rows %0d,%0d,%0d",
                 it, y, obs_done_at, obs_row[2], obs_row[3], obs_row[4], m_row[0], m_row[1], m_row[2]);
      else n_pass++;
      sweep_line(1'b1, nb, non, lh, msg);
      n_total++; if (nb !== 0) $display("FAIL rand_sweep[%0d]: y=%0d %0d bad, first %s", it, y, nb, msg); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = {$urandom, $urandom};
    rom_mem[0] = 64'h0000_7FFF_0000_0001;
    rom_mem[6] = 64'hF0F0_00FF_1234_8001;
    model_clear();
    test_reset();
    test_full_mole();
    test_mid_fetch_reset();
    test_partial_rise();
    test_hidden_row();
    test_no_band();
    test_overrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mole_line_fetcher.md
Name: mole_line_fetcher

Overview:
- Shares the single 32-row x 64-bit mole sprite ROM among the nine holes of the 3x3 playfield grid.
- During each horizontal blank it sequences ROM reads for the three holes in the upcoming scanline's band and latches them into per-column line buffers.
- During active video it serializes those buffers into a registered sprite pixel stream for the VGA colour mux.
- Applies per-hole pop-up height so moles rise bottom-aligned out of their holes.

Parameters:
- HOLE_X0, 96, x of left edge of column 0
- PITCH_X, 192, horizontal distance between column left edges
- HOLE_Y0, 112, y of top edge of band 0
- PITCH_Y, 128, vertical distance between band top edges
- SPRITE_W, 64, sprite width in pixels (fixed by ROM word width)
- SPRITE_H, 32, sprite height in rows (fixed by ROM address width)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse at start of hblank preceding line next_y
- next_y  in  10  y of the line about to be displayed
- x  in  10  current pixel column
- video_on  in  1  active-video qualifier
- mole_up  in  9  per-hole visible flag, bit index = band*3+col
- pop_level  in  54  per-hole visible row count 0..32, 6 bits each, hole i at [6i+5:6i]
- rom_row  out  5  sprite ROM row address
- rom_data  in  64  sprite ROM pattern, combinational from rom_row; bit 63 = leftmost pixel
- pixel_on  out  1  sprite pixel opaque at registered x
- pixel_hole  out  4  hole index 0..8 owning pixel_on; 15 when none
- busy  out  1  fetch sequence in progress
- fetch_done  out  1  one-cycle pulse when line buffers are updated
- overrun  out  1  sticky: line_start arrived while busy

Behaviour:
- Reset: state IDLE; rom_row=0; all buffers and valid bits 0; pixel_on=0; pixel_hole=15; busy=0; fetch_done=0; overrun=0.
- FSM: IDLE -> SETUP -> F0 -> F1 -> F2 -> IDLE.
  - IDLE -> SETUP on line_start.
  - Every other transition is unconditional.
- line_start sampled in IDLE:
  - Snapshot next_y, mole_up and pop_level.
  - Compute band b = the b in 0..2 with HOLE_Y0+b*PITCH_Y <= next_y < that +32, and r = next_y - band top.
  - No band: hit=0 and every column's valid bit is forced 0.
- SETUP: rom_row <= row for col 0.
- Fc (c = 0..2):
  - Latch buf[c] <= rom_data and set valid[c].
  - Drive rom_row for col c+1 (F2 leaves rom_row unchanged).
- Row and valid rule for hole h=b*3+c with level L = min(pop_level[h], 32):
  - valid = hit & mole_up[h] & (L>0) & (r >= 32-L).
  - Row = r-(32-L) when valid, else 0.
- Timing:
  - busy is high in SETUP, F0, F1 and F2.
  - fetch_done pulses in the first IDLE cycle after F2, a fixed 5 cycles after the line_start edge.
  - Latency is constant whether or not a band is hit.
- line_start while busy: ignored with no restart; overrun is set to 1 and cleared only by reset.
- Buffers hold until the next completed F0..F2 write. Writes during video_on are not blocked, so the integrator issues line_start in hblank only.
- Pixel path (1-cycle registered latency):
  - Column c is selected when HOLE_X0+c*PITCH_X <= x < that +64 and valid[c].
  - pixel_on <= video_on & selected & buf[c][63-(x-colx)].
  - pixel_hole <= b*3+c when pixel_on is 1, else 15.
- Columns never overlap because PITCH_X >= 64; this is enforced by an elaboration check.
- All coordinate arithmetic is unsigned 10-bit. Offsets are computed only after the lower-bound compare, so no wraparound occurs.
- Reset mid-fetch returns to IDLE immediately with all state cleared.

Decomposition:
- Shared package mole_pkg holds:
  - SPRITE_W, SPRITE_H, the grid dimensions (3x3) and NO_HOLE=15.
  - The FSM state enum {IDLE, SETUP, F0, F1, F2}.
- Sub-module mole_hole_locator is combinational. It maps next_y and pop_level to band hit, b, r and per-column rows/valids, and is instantiated once.
- The ROM itself stays external, connected via rom_row/rom_data.

Test Plan:
- Reset check: assert reset 3 cycles -> pixel_on=0, pixel_hole=15, busy=0, rom_row=0, overrun=0; release, sweep x 0..639 with video_on=1 -> pixel_on stays 0.
- Full mole: mole_up=9'h001, level[0]=32, line_start with next_y=112:
  - rom_row=0 in F0; fetch_done 5 cycles later.
  - x=96 -> pixel_on=0.
  - x=113 -> pixel_on=1 and pixel_hole=0, one cycle after x is presented.
- Partial rise: level[4]=8, mole_up=9'h010, next_y=270 (band 1, r=30) -> rom_row=6 in F1, pixel_hole=4 on opaque pixels in x 288..351.
- Partial rise, hidden row: same setup with next_y=252 (r=12) -> valid[1]=0, pixel_on=0 across the line.
- No band: next_y=200 -> all valid 0, fetch_done still pulses at +5, pixel_on=0 everywhere.
- Overrun: line_start again 2 cycles after the first -> sequence not restarted, fetch_done pulses once, overrun=1 until reset.
